// File: rtl/echo_frame_sequencer.sv
// Per-frame sequencer for the echo-cancellation datapath: conversion, lag,
// adaptation or cancellation, then output. Stages hand off on ready, and every wait is bounded.
module echo_frame_sequencer #(
   parameter int MAX_ITER  = 64,
   parameter int PULSE_LEN = 4,
   parameter int TIMEOUT   = 1023
) (
   input  logic        clk_operation,
   input  logic        rst,
   input  logic [12:0] sampling_cycle_counter,
   input  logic        train_restart,
   input  logic        ready_conv,
   input  logic        ready_lag,
   input  logic        ready_approx,
   input  logic        ready_cancel,
   input  logic [63:0] e,
   input  logic [63:0] signal_without_echo,
   output logic        enable_conv,
   output logic        enable_lag,
   output logic        enable_approx,
   output logic        enable_cancel,
   output logic        enable_sampling_lag,
   output logic        enable_sampling_approx,
   output logic        enable_sampling_cancel,
   output logic        enable_out,
   output logic [63:0] double_out,
   output logic [15:0] iteration,
   output logic        mode,
   output logic        busy,
   output logic        timeout_err,
   output logic        overrun_err
);

   // Each pulse state is immediately followed by its wait state, so P -> W is state + 1.
   localparam logic [3:0] IDLE   = 4'd0;
   localparam logic [3:0] CONV_P = 4'd1;
   localparam logic [3:0] CONV_W = 4'd2;
   localparam logic [3:0] LAG_P  = 4'd3;
   localparam logic [3:0] LAG_W  = 4'd4;
   localparam logic [3:0] ADP_P  = 4'd5;
   localparam logic [3:0] ADP_W  = 4'd6;
   localparam logic [3:0] CAN_P  = 4'd7;
   localparam logic [3:0] CAN_W  = 4'd8;
   localparam logic [3:0] EMIT   = 4'd9;

   logic [3:0]  state, state_next;
   logic [15:0] pulse_cnt, pulse_cnt_next;
   logic [11:0] wait_cnt, wait_cnt_next;
   logic [63:0] capture;
   logic [15:0] iter_inc;
   logic        restart_pending;
   logic        frame_start;
   logic        stage_ready;
   logic        timed_out;
   logic        lag_exit;

   assign frame_start = (sampling_cycle_counter == 13'd0);
   assign iter_inc    = (iteration == 16'hFFFF) ? iteration : iteration + 16'd1;

   always_comb begin
      stage_ready = 1'b0;
      case (state)
         CONV_W:  stage_ready = ready_conv;
         LAG_W:   stage_ready = ready_lag;
         ADP_W:   stage_ready = ready_approx;
         CAN_W:   stage_ready = ready_cancel;
         default: stage_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_next     = state;
      pulse_cnt_next = pulse_cnt;
      wait_cnt_next  = wait_cnt;
      timed_out      = 1'b0;
      lag_exit       = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_next     = CONV_P;
               pulse_cnt_next = 16'd0;
            end
         end
         CONV_P, LAG_P, ADP_P, CAN_P: begin
            if (pulse_cnt == 16'(PULSE_LEN - 1)) begin
               state_next    = state + 4'd1;
               wait_cnt_next = 12'd0;
            end else begin
               pulse_cnt_next = pulse_cnt + 16'd1;
            end
         end
         CONV_W, LAG_W, ADP_W, CAN_W: begin
            // A ready still high from the previous frame must not count, so wait count 0 is a guard.
            if (wait_cnt != 12'd0 && stage_ready) begin
               pulse_cnt_next = 16'd0;
               case (state)
                  CONV_W: state_next = LAG_P;
                  LAG_W: begin
                     state_next = mode ? CAN_P : ADP_P;
                     lag_exit   = 1'b1;
                  end
                  default: state_next = EMIT;
               endcase
            end else if (wait_cnt == 12'(TIMEOUT)) begin
               state_next = IDLE;
               timed_out  = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt + 12'd1;
            end
         end
         EMIT:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_operation or negedge rst) begin
      if (!rst) begin
         state                  <= IDLE;
         pulse_cnt              <= 16'd0;
         wait_cnt               <= 12'd0;
         capture                <= 64'd0;
         restart_pending        <= 1'b0;
         enable_conv            <= 1'b0;
         enable_lag             <= 1'b0;
         enable_approx          <= 1'b0;
         enable_cancel          <= 1'b0;
         enable_sampling_lag    <= 1'b1;
         enable_sampling_approx <= 1'b0;
         enable_sampling_cancel <= 1'b0;
         enable_out             <= 1'b0;
         double_out             <= 64'd0;
         iteration              <= 16'd0;
         mode                   <= 1'b0;
         busy                   <= 1'b0;
         timeout_err            <= 1'b0;
         overrun_err            <= 1'b0;
      end else begin
         state         <= state_next;
         pulse_cnt     <= pulse_cnt_next;
         wait_cnt      <= wait_cnt_next;
         enable_conv   <= (state_next == CONV_P);
         enable_lag    <= (state_next == LAG_P);
         enable_approx <= (state_next == ADP_P);
         enable_cancel <= (state_next == CAN_P);
         busy          <= (state_next != IDLE);

         if (state != IDLE && frame_start) overrun_err <= 1'b1;
         if (timed_out) timeout_err <= 1'b1;
         if (lag_exit) begin
            enable_sampling_approx <= 1'b1;
            enable_sampling_cancel <= 1'b1;
         end
         if (state == ADP_W && state_next == EMIT) capture <= e;
         if (state == CAN_W && state_next == EMIT) capture <= signal_without_echo;
         if (state == EMIT) begin
            double_out <= capture;
            enable_out <= 1'b1;
         end

         // mode only moves while idle or on the frame's final edge, so a frame never sees it change.
         if (state == IDLE) begin
            if (train_restart) begin
               iteration       <= 16'd0;
               mode            <= 1'b0;
               restart_pending <= 1'b0;
            end
         end else if (state == EMIT || timed_out) begin
            if (restart_pending || train_restart) begin
               iteration       <= 16'd0;
               mode            <= 1'b0;
               restart_pending <= 1'b0;
            end else if (state == EMIT && !mode) begin
               iteration <= iter_inc;
               mode      <= (iter_inc >= 16'(MAX_ITER));
            end
         end else if (train_restart) begin
            restart_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_echo_frame_sequencer.sv
// Randomized frame-level bench: a driver issues frames and pushes expected outcomes,
// a monitor pops them at each frame end and also polices pulse lengths and stage choice.
module tb_echo_frame_sequencer;

   localparam int MAX_ITER  = 64;
   localparam int PULSE_LEN = 4;
   localparam int TIMEOUT   = 1023;

   logic        clk_operation = 1'b0;
   logic        rst = 1'b0;
   logic [12:0] sampling_cycle_counter = 13'd1;
   logic        train_restart = 1'b0;
   logic        ready_conv = 1'b0, ready_lag = 1'b0, ready_approx = 1'b0, ready_cancel = 1'b0;
   logic [63:0] e = 64'd0, signal_without_echo = 64'd0;
   logic        enable_conv, enable_lag, enable_approx, enable_cancel;
   logic        enable_sampling_lag, enable_sampling_approx, enable_sampling_cancel;
   logic        enable_out, mode, busy, timeout_err, overrun_err;
   logic [63:0] double_out;
   logic [15:0] iteration;

   echo_frame_sequencer #(.MAX_ITER(MAX_ITER), .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk_operation(clk_operation), .rst(rst),
      .sampling_cycle_counter(sampling_cycle_counter), .train_restart(train_restart),
      .ready_conv(ready_conv), .ready_lag(ready_lag), .ready_approx(ready_approx),
      .ready_cancel(ready_cancel), .e(e), .signal_without_echo(signal_without_echo),
      .enable_conv(enable_conv), .enable_lag(enable_lag), .enable_approx(enable_approx),
      .enable_cancel(enable_cancel), .enable_sampling_lag(enable_sampling_lag),
      .enable_sampling_approx(enable_sampling_approx),
      .enable_sampling_cancel(enable_sampling_cancel), .enable_out(enable_out),
      .double_out(double_out), .iteration(iteration), .mode(mode), .busy(busy),
      .timeout_err(timeout_err), .overrun_err(overrun_err)
   );

   always #5 clk_operation = ~clk_operation;

   typedef struct {
      logic [63:0] dout;
      int          iter;
      bit          mode;
      bit          terr;
      bit          oerr;
      bit          eout;
      int          n_app;
      int          n_can;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state, updated from the behavioural frame rules.
   logic [63:0] m_dout = 64'd0;
   int          m_iter = 0;
   bit          m_mode = 1'b0;
   bit          m_terr = 1'b0;
   bit          m_oerr = 1'b0;
   bit          m_eout = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
   endtask

   function automatic logic en_of(input int s);
      case (s)
         0:       return enable_conv;
         1:       return enable_lag;
         2:       return enable_approx;
         default: return enable_cancel;
      endcase
   endfunction

   task automatic set_ready(input int s, input logic v);
      case (s)
         0:       ready_conv   = v;
         1:       ready_lag    = v;
         2:       ready_approx = v;
         default: ready_cancel = v;
      endcase
   endtask

   task automatic wait_en(input int s, input logic lvl, output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 100) begin
         @(negedge clk_operation);
         n++;
         if (en_of(s) == lvl) ok = 1'b1;
      end
      if (!ok) check($sformatf("wait_enable_%0d", s), {63'd0, en_of(s)}, {63'd0, lvl});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 2000) begin
         @(negedge clk_operation);
         n++;
      end
      if (busy) check("wait_idle", {63'd0, busy}, 64'd0);
   endtask

   task automatic run_frame(input bit conv_hold, input bit spike, input bit lag_never,
                            input bit restart_can);
      exp_t x;
      bit   fm, ok;
      int   n, last;
      fm = m_mode;
      last = fm ? 3 : 2;
      e = {$urandom, $urandom};
      signal_without_echo = {$urandom, $urandom};
      if (spike) m_oerr = 1'b1;
      if (lag_never) begin
         m_terr = 1'b1;
      end else begin
         m_dout = fm ? signal_without_echo : e;
         m_eout = 1'b1;
         if (restart_can) begin
            m_iter = 0;
            m_mode = 1'b0;
         end else if (!fm) begin
            if (m_iter < 65535) m_iter++;
            if (m_iter >= MAX_ITER) m_mode = 1'b1;
         end
      end
      x.dout = m_dout; x.iter = m_iter; x.mode = m_mode; x.terr = m_terr;
      x.oerr = m_oerr; x.eout = m_eout;
      x.n_app = (lag_never || fm) ? 0 : 1;
      x.n_can = (!lag_never && fm) ? 1 : 0;
      exp_q.push_back(x);

      @(negedge clk_operation);
      sampling_cycle_counter = 13'd0;
      @(negedge clk_operation);
      sampling_cycle_counter = 13'($urandom_range(1, 8191));
      if (conv_hold) ready_conv = 1'b1;
      wait_en(0, 1'b1, n, ok);
      wait_en(0, 1'b0, n, ok);
      if (!conv_hold) begin
         repeat ($urandom_range(0, 3)) @(negedge clk_operation);
         ready_conv = 1'b1;
      end
      wait_en(1, 1'b1, n, ok);
      // Held ready: one guard cycle, one advance cycle, then the lag pulse.
      if (conv_hold) check("ready_held_gap", 64'(n), 64'd2);
      ready_conv = 1'b0;
      wait_en(1, 1'b0, n, ok);
      if (lag_never) begin
         wait_idle();
      end else begin
         repeat ($urandom_range(0, 3)) @(negedge clk_operation);
         ready_lag = 1'b1;
         wait_en(last, 1'b1, n, ok);
         ready_lag = 1'b0;
         wait_en(last, 1'b0, n, ok);
         if (spike) begin
            sampling_cycle_counter = 13'd0;
            @(negedge clk_operation);
            sampling_cycle_counter = 13'd5;
         end
         if (restart_can) begin
            train_restart = 1'b1;
            @(negedge clk_operation);
            train_restart = 1'b0;
         end
         repeat ($urandom_range(0, 3)) @(negedge clk_operation);
         set_ready(last, 1'b1);
         wait_idle();
         set_ready(last, 1'b0);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk_operation);
   endtask

   // Monitor: pulse lengths, per-frame stage counts, and frame-end scoreboard.
   int run_len[4] = '{0, 0, 0, 0};
   int rises[4]   = '{0, 0, 0, 0};
   logic prev_busy = 1'b0;
   always @(negedge clk_operation) begin
      logic [3:0] en;
      exp_t x;
      en = {enable_cancel, enable_approx, enable_lag, enable_conv};
      if (rst) begin
         for (int s = 0; s < 4; s++) begin
            if (en[s]) begin
               if (run_len[s] == 0) rises[s]++;
               run_len[s]++;
            end else if (run_len[s] != 0) begin
               check($sformatf("pulse_len_%0d", s), 64'(run_len[s]), 64'(PULSE_LEN));
               run_len[s] = 0;
            end
         end
         if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_frame_end", 64'd1, 64'd0);
            end else begin
               x = exp_q.pop_front();
               check("double_out", double_out, x.dout);
               check("iteration", 64'(iteration), 64'(x.iter));
               check("mode", {63'd0, mode}, {63'd0, x.mode});
               check("timeout_err", {63'd0, timeout_err}, {63'd0, x.terr});
               check("overrun_err", {63'd0, overrun_err}, {63'd0, x.oerr});
               check("enable_out", {63'd0, enable_out}, {63'd0, x.eout});
               check("conv_pulses", 64'(rises[0]), 64'd1);
               check("approx_pulses", 64'(rises[2]), 64'(x.n_app));
               check("cancel_pulses", 64'(rises[3]), 64'(x.n_can));
               $display("frame end: iter=%0d mode=%0d dout=%h terr=%0d oerr=%0d",
                        iteration, mode, double_out, timeout_err, overrun_err);
            end
            for (int s = 0; s < 4; s++) rises[s] = 0;
         end
      end
      prev_busy = busy;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk_operation);
      check("rst_enable_conv", {63'd0, enable_conv}, 64'd0);
      check("rst_enable_lag", {63'd0, enable_lag}, 64'd0);
      check("rst_enable_approx", {63'd0, enable_approx}, 64'd0);
      check("rst_enable_cancel", {63'd0, enable_cancel}, 64'd0);
      check("rst_enable_out", {63'd0, enable_out}, 64'd0);
      check("rst_samp_lag", {63'd0, enable_sampling_lag}, 64'd1);
      check("rst_samp_approx", {63'd0, enable_sampling_approx}, 64'd0);
      check("rst_samp_cancel", {63'd0, enable_sampling_cancel}, 64'd0);
      check("rst_double_out", double_out, 64'd0);
      check("rst_iteration", 64'(iteration), 64'd0);
      check("rst_mode", {63'd0, mode}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
      check("rst_overrun_err", {63'd0, overrun_err}, 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk_operation);

      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      check("samp_approx_set", {63'd0, enable_sampling_approx}, 64'd1);
      check("samp_cancel_set", {63'd0, enable_sampling_cancel}, 64'd1);
      check("samp_lag_kept", {63'd0, enable_sampling_lag}, 64'd1);
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);
      run_frame(1'b0, 1'b1, 1'b0, 1'b0);
      run_frame(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 100 && !m_mode; i++) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(1'b0, 1'b0, 1'b0, 1'b1);
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk_operation);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
